// File: rtl/vector_packer.sv
// Serial-to-parallel packer: collects up to NUM signed WIDTH-bit words into one
// packed NUM*WIDTH vector (lane k at [k*WIDTH +: WIDTH]), zero-filling short
// vectors closed early by in_last, and presents it on a valid/ready output.
module vector_packer #(
   parameter int unsigned NUM   = 2,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_valid,
   input  logic                 in_last,
   output logic                 in_ready,
   output logic [NUM*WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]     out_count,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int unsigned VEC_W = NUM * WIDTH;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM - 1);

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] wr_lane;
   logic [VEC_W-1:0] next_vec;
   logic             accept;
   logic             xfer;
   logic             close;

   // While FULL, an accepted word can only enter when the held vector leaves,
   // so input readiness follows the downstream ready in that state.
   assign in_ready = (state == FILL) || out_ready;
   assign accept   = in_valid && in_ready;
   assign xfer     = out_valid && out_ready;

   // A word accepted while FULL always starts the next vector at lane 0.
   assign wr_lane  = (state == FULL) ? '0 : cnt;
   assign close    = in_last || (wr_lane == LAST_LANE);

   // Vector image after writing the current word; lane 0 clears all other lanes.
   always_comb begin
      next_vec = out_data;
      for (int unsigned k = 0; k < NUM; k++) begin
         if (CNT_W'(k) == wr_lane) begin
            next_vec[k*WIDTH +: WIDTH] = in_data;
         end else if (wr_lane == '0) begin
            next_vec[k*WIDTH +: WIDTH] = '0;
         end
      end
   end

   // Fill/full control, lane counter and registered output vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= FILL;
         cnt       <= '0;
         out_data  <= '0;
         out_count <= '0;
         out_valid <= 1'b0;
      end else begin
         if (accept) begin
            out_data <= next_vec;
            if (close) begin
               state     <= FULL;
               out_valid <= 1'b1;
               out_count <= CNT_W'(wr_lane + 1'b1);
               cnt       <= '0;
            end else begin
               state     <= FILL;
               out_valid <= 1'b0;
               cnt       <= CNT_W'(wr_lane + 1'b1);
            end
         end else if (xfer) begin
            state     <= FILL;
            out_valid <= 1'b0;
            cnt       <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vector_packer.sv
// Bench for vector_packer: directed steps over four lane counts plus a random
// handshake phase scored against a word-list model of the packing rules.
module tb_vector_packer;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // NUM=4, WIDTH=8
   logic [7:0]  in_data4;
   logic        in_valid4, in_last4, in_ready4, out_valid4, out_ready4;
   logic [31:0] out_data4;
   logic [2:0]  out_count4;
   // NUM=2, WIDTH=32
   logic [31:0] in_data2;
   logic        in_valid2, in_last2, in_ready2, out_valid2, out_ready2;
   logic [63:0] out_data2;
   logic [1:0]  out_count2;
   // NUM=3, WIDTH=8
   logic [7:0]  in_data3;
   logic        in_valid3, in_last3, in_ready3, out_valid3, out_ready3;
   logic [23:0] out_data3;
   logic [1:0]  out_count3;
   // NUM=1, WIDTH=8
   logic [7:0]  in_data1;
   logic        in_valid1, in_last1, in_ready1, out_valid1, out_ready1;
   logic [7:0]  out_data1;
   logic [0:0]  out_count1;

   vector_packer #(.NUM(4), .WIDTH(8), .CNT_W(3)) u4 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4),
      .in_last(in_last4), .in_ready(in_ready4), .out_data(out_data4),
      .out_count(out_count4), .out_valid(out_valid4), .out_ready(out_ready4));
   vector_packer #(.NUM(2), .WIDTH(32), .CNT_W(2)) u2 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2),
      .in_last(in_last2), .in_ready(in_ready2), .out_data(out_data2),
      .out_count(out_count2), .out_valid(out_valid2), .out_ready(out_ready2));
   vector_packer #(.NUM(3), .WIDTH(8), .CNT_W(2)) u3 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
      .in_last(in_last3), .in_ready(in_ready3), .out_data(out_data3),
      .out_count(out_count3), .out_valid(out_valid3), .out_ready(out_ready3));
   vector_packer #(.NUM(1), .WIDTH(8), .CNT_W(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
      .in_last(in_last1), .in_ready(in_ready1), .out_data(out_data1),
      .out_count(out_count1), .out_valid(out_valid1), .out_ready(out_ready1));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [7:0]  words[12];
   logic [7:0]  cur[$];
   logic [31:0] exp_vec[$];
   logic [2:0]  exp_cnt[$];
   logic [31:0] v;
   logic [31:0] held;
   logic [63:0] held2;
   int          bubbles, xfers, xfers1;
   bit          pend;

   initial begin
      words = '{8'h01, 8'h02, 8'h03, 8'h84, 8'h05, 8'h06, 8'h07, 8'h08,
                8'hFF, 8'hFF, 8'hFF, 8'hFF};
      rst_n = 1'b0;
      in_data4 = '0; in_valid4 = 0; in_last4 = 0; out_ready4 = 0;
      in_data2 = '0; in_valid2 = 0; in_last2 = 0; out_ready2 = 0;
      in_data3 = '0; in_valid3 = 0; in_last3 = 0; out_ready3 = 0;
      in_data1 = '0; in_valid1 = 0; in_last1 = 0; out_ready1 = 0;
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();

      // Reset state
      check("rst_out_valid", 64'(out_valid4), 64'd0);
      check("rst_out_data",  64'(out_data4),  64'd0);
      check("rst_out_count", 64'(out_count4), 64'd0);
      check("rst_in_ready",  64'(in_ready4),  64'd1);

      // Three back-to-back full vectors, NUM=4
      out_ready4 = 1; in_valid4 = 1; in_last4 = 0;
      bubbles = 0; xfers = 0;
      for (int i = 0; i < 12; i++) begin
         in_data4 = words[i];
         #1;
         if (!in_ready4) bubbles++;
         if (out_valid4 && out_ready4) xfers++;
         if (i == 4) begin
            check("vec1_valid", 64'(out_valid4), 64'd1);
            check("vec1_data",  64'(out_data4),  64'h84030201);
            check("vec1_count", 64'(out_count4), 64'd4);
         end
         if (i == 8) check("vec2_data", 64'(out_data4), 64'h08070605);
         cyc();
      end
      check("vec3_valid", 64'(out_valid4), 64'd1);
      check("vec3_data",  64'(out_data4),  64'hFFFFFFFF);
      check("b2b_bubbles", 64'(bubbles), 64'd0);
      check("b2b_xfers",   64'(xfers),   64'd2);

      // Short vector closed by in_last after an all-ones vector
      in_data4 = 8'h11; in_last4 = 0;
      cyc();
      in_data4 = 8'h22; in_last4 = 1;
      cyc();
      check("short_valid", 64'(out_valid4), 64'd1);
      check("short_data",  64'(out_data4),  64'h00002211);
      check("short_count", 64'(out_count4), 64'd2);
      in_valid4 = 0; in_last4 = 0;
      cyc();
      check("short_drained", 64'(out_valid4), 64'd0);

      // Backpressure, NUM=2 WIDTH=32
      out_ready2 = 0; in_valid2 = 1; in_data2 = 32'hFFFFFFFF;
      cyc();
      in_data2 = 32'd5;
      cyc();
      check("bp_valid", 64'(out_valid2), 64'd1);
      check("bp_data",  out_data2, 64'h00000005_FFFFFFFF);
      check("bp_count", 64'(out_count2), 64'd2);
      in_data2 = 32'h123;
      for (int j = 0; j < 5; j++) begin
         #1;
         check("bp_in_ready_low", 64'(in_ready2),  64'd0);
         check("bp_hold_valid",   64'(out_valid2), 64'd1);
         check("bp_hold_data",    out_data2, 64'h00000005_FFFFFFFF);
         cyc();
      end
      out_ready2 = 1;
      #1;
      check("bp_in_ready_high", 64'(in_ready2), 64'd1);
      cyc();
      check("bp_after_valid", 64'(out_valid2), 64'd0);
      check("bp_next_lane0",  64'(out_data2[31:0]), 64'h123);
      in_data2 = 32'h456;
      cyc();
      check("bp_next_valid", 64'(out_valid2), 64'd1);
      check("bp_next_data",  out_data2, 64'h00000456_00000123);
      in_valid2 = 0;
      cyc();

      // Simultaneous transfer and accept, NUM=3
      out_ready3 = 0; in_valid3 = 1; in_last3 = 0;
      in_data3 = 8'h01; cyc();
      in_data3 = 8'h02; cyc();
      in_data3 = 8'h03; cyc();
      check("sim_full_data",  64'(out_data3),  64'h030201);
      check("sim_full_count", 64'(out_count3), 64'd3);
      out_ready3 = 1; in_data3 = 8'h07;
      cyc();
      check("sim_valid_after", 64'(out_valid3), 64'd0);
      check("sim_lane0_clear", 64'(out_data3),  64'h000007);
      in_data3 = 8'h08; cyc();
      in_data3 = 8'h09; cyc();
      check("sim_next_data",  64'(out_data3),  64'h090807);
      check("sim_next_count", 64'(out_count3), 64'd3);
      in_data3 = 8'h0A; in_last3 = 1;
      cyc();
      check("sim_last_valid", 64'(out_valid3), 64'd1);
      check("sim_last_data",  64'(out_data3),  64'h00000A);
      check("sim_last_count", 64'(out_count3), 64'd1);
      // Leave a held vector in place for the reset test
      out_ready3 = 0; in_data3 = 8'h31;
      cyc();
      in_valid3 = 0; in_last3 = 0;
      cyc();
      check("hold_before_rst", 64'(out_valid3), 64'd1);

      // Reset mid-fill
      out_ready4 = 1; in_valid4 = 1;
      in_data4 = 8'h21; cyc();
      in_data4 = 8'h22; cyc();
      in_valid4 = 0;
      rst_n = 0;
      #2;
      check("mid_rst_valid", 64'(out_valid4), 64'd0);
      check("mid_rst_data",  64'(out_data4),  64'd0);
      check("mid_rst_count", 64'(out_count4), 64'd0);
      check("full_rst_valid", 64'(out_valid3), 64'd0);
      #2;
      rst_n = 1;
      cyc();
      in_valid4 = 1;
      for (int i = 0; i < 4; i++) begin
         in_data4 = 8'(8'h10 + i);
         cyc();
      end
      check("post_rst_data",  64'(out_data4),  64'h13121110);
      check("post_rst_count", 64'(out_count4), 64'd4);
      in_valid4 = 0;
      cyc();

      // NUM=1 stream
      out_ready1 = 1; in_valid1 = 1; xfers1 = 0;
      for (int i = 0; i < 3; i++) begin
         in_data1 = 8'(8'h0A + i);
         #1;
         if (out_valid1 && out_ready1) xfers1++;
         cyc();
         check("n1_valid", 64'(out_valid1), 64'd1);
         check("n1_data",  64'(out_data1),  64'(8'h0A + i));
         check("n1_count", 64'(out_count1), 64'd1);
      end
      in_valid1 = 0;
      #1;
      if (out_valid1 && out_ready1) xfers1++;
      cyc();
      check("n1_xfers", 64'(xfers1), 64'd3);
      check("n1_idle",  64'(out_valid1), 64'd0);

      // Random handshakes on NUM=4 against a word-list model
      pend = 0;
      for (int n = 0; n < 800; n++) begin
         if (!pend) begin
            in_valid4 = ($urandom_range(0, 9) < 7);
            in_data4  = 8'($urandom);
            in_last4  = ($urandom_range(0, 4) == 0);
         end
         out_ready4 = (n >= 790) ? 1'b1 : ($urandom_range(0, 9) < 6);
         if (n >= 790) in_valid4 = 0;
         #1;
         if (out_valid4 && out_ready4) begin
            if (exp_vec.size() == 0) begin
               check("rnd_pending", 64'(exp_vec.size()), 64'd1);
            end else begin
               check("rnd_data",  64'(out_data4),  64'(exp_vec.pop_front()));
               check("rnd_count", 64'(out_count4), 64'(exp_cnt.pop_front()));
            end
         end
         if (in_valid4 && in_ready4) begin
            cur.push_back(in_data4);
            if (cur.size() == 4 || in_last4) begin
               v = '0;
               foreach (cur[k]) v = v | (32'(cur[k]) << (8 * k));
               exp_vec.push_back(v);
               exp_cnt.push_back(3'(cur.size()));
               cur.delete();
            end
            pend = 0;
         end else begin
            pend = in_valid4;
         end
         cyc();
      end
      check("rnd_drained_queue", 64'(exp_vec.size()), 64'd0);
      check("rnd_drained_valid", 64'(out_valid4), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vector_packer.md
Name: vector_packer

Overview:
- Serial-to-parallel packer that builds the packed NUM*WIDTH operand bus consumed by the N-input adder tree and related lane-parallel blocks in the LSTM datapath.
- Accepts one signed WIDTH-bit word per valid/ready handshake and places word k at bits [k*WIDTH +: WIDTH].
- Presents the completed vector on a valid/ready output. Short vectors, terminated by in_last, are zero-filled, so a downstream sum is unaffected.

Parameters:
- NUM, 2, number of lanes per vector; legal range ≥1.
- WIDTH, 32, bits per lane (signed two's complement).
- CNT_W, 2, width of the lane counter and of out_count; must satisfy 2^CNT_W > NUM.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  signed word for the current lane
- in_valid  input  1  in_data is valid
- in_last  input  1  current word closes the vector early; qualified by in_valid
- in_ready  output  1  packer can accept a word this cycle
- out_data  output  NUM*WIDTH  packed vector; lane k at [k*WIDTH +: WIDTH]
- out_count  output  CNT_W  number of lanes actually written (1..NUM)
- out_valid  output  1  out_data/out_count are valid
- out_ready  input  1  downstream accepts the vector

Behaviour:
- Reset (async assert, sync-safe deassert on clk): state=FILL, lane counter=0, out_data=0, out_count=0, out_valid=0. in_ready is 1 from the first cycle after rst_n deasserts.
- A word is accepted when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- State FILL:
  - in_ready=1 and out_valid=0.
  - On accept with counter=c: lane c ← in_data.
  - If c==0, all other lanes are cleared to 0 in the same edge.
  - If c==NUM-1 or in_last=1: go to FULL, out_count←c+1, counter←0.
  - Otherwise counter←c+1.
- State FULL:
  - out_valid=1; out_data and out_count are held stable while out_ready=0.
  - in_ready=out_ready (combinational). This allows back-to-back vectors with no bubble.
  - If an output transfer and an accept happen in the same cycle: the accepted word is written as lane 0 of the next vector and other lanes are cleared. If that word also has in_last=1 or NUM==1, stay FULL with out_count=1; otherwise go to FILL with counter=1.
  - Output transfer without accept: go to FILL, counter=0. out_data keeps its old value; it is don't-care when out_valid=0 but must not be X.
- Latency: out_valid rises on the clock edge that accepts the final word of a vector (visible the following cycle).
- Throughput: NUM words per NUM cycles with continuous valid/ready.
- in_last on lane NUM-1 is legal and redundant. in_last on lane 0 gives out_count=1 with lanes 1..NUM-1 equal to 0.
- in_data and in_last are ignored when in_valid=0.
- No arithmetic is performed. Data is stored bit-exact; zero fill is all-zero bits.
- Reset asserted mid-fill or while FULL discards the partial or held vector immediately. out_valid drops asynchronously.
- NUM=1: every accepted word moves the block to FULL with out_count=1.
- Upstream must hold in_data, in_valid and in_last stable until accepted; the packer does not check this.
- Downstream must tolerate out_valid held indefinitely.

Test Plan:
- Full vector, NUM=4, WIDTH=8, out_ready=1: send 0x01,0x02,0x03,0x84 on 4 consecutive cycles -> out_valid one cycle after the 4th accept, out_data=0x84030201, out_count=4. Expect 0 bubbles over 3 back-to-back vectors (12 words in 12 cycles).
- Short vector, NUM=4: after a prior vector 0xFFFFFFFF, send 0x11, 0x22 with in_last on 0x22 -> out_data=0x00002211, out_count=2.
- Backpressure, NUM=2, WIDTH=32: complete vector {-1, 5} with out_ready=0 for 5 cycles -> out_valid=1, out_data stable at 0x00000005_FFFFFFFF, in_ready=0 throughout. Raise out_ready -> transfer, and in_ready=1 in the same cycle.
- Simultaneous transfer and accept, NUM=3, while FULL: raise out_ready with in_valid=1, in_data=0x7 -> old vector transfers; next vector has lane 0=0x7, lanes 1-2=0, state FILL, counter=1.
- Reset mid-fill: after 2 of 4 words, pulse rst_n low for a half cycle -> out_valid=0, out_data=0, out_count=0. A subsequent 4-word vector packs from lane 0 correctly.
- NUM=1: stream 0xA, 0xB, 0xC with out_ready=1 -> three output transfers on consecutive cycles, each with out_count=1.
